// File: rtl/dir_button_encoder.sv
// dir_button_encoder: synchronise and debounce four N/E/S/W buttons, then emit a 2-bit direction with a one-cycle valid pulse.
// Optional auto-repeat while a single accepted button stays held: define DIR_AUTOREPEAT_EN.
module dir_button_encoder #(
    parameter int DEBOUNCE_CYCLES = 16,
    parameter int REPEAT_CYCLES   = 64
) (
    input  logic       clk_i,
    input  logic       reset_i,
    input  logic [3:0] buttons_i,
    output logic [1:0] direction_o,
    output logic       valid_o
);
    localparam int MAXC = (DEBOUNCE_CYCLES > REPEAT_CYCLES) ? DEBOUNCE_CYCLES : REPEAT_CYCLES;
    localparam int CW = (MAXC > 2) ? $clog2(MAXC) : 1;
    localparam logic [CW-1:0] DEB_LAST = CW'(DEBOUNCE_CYCLES - 1);

    typedef enum logic [1:0] {IDLE, PRESS, HELD} state_t;

    state_t        state;
    logic [3:0]    sync_d;
    logic [3:0]    sync_q;
    logic [3:0]    cap;
    logic [CW-1:0] cnt;
    logic          any;
    logic          one_hot;
    logic [1:0]    enc;
    logic          rep_fire;

    assign any     = |sync_q;
    assign one_hot = any && ((sync_q & (sync_q - 4'd1)) == 4'd0);
    assign enc     = {cap[3] | cap[2], cap[3] | cap[1]};

    // two-flop synchroniser; everything downstream looks only at sync_q
    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            sync_d <= 4'b0000;
            sync_q <= 4'b0000;
        end else begin
            sync_d <= buttons_i;
            sync_q <= sync_d;
        end
    end

`ifdef DIR_AUTOREPEAT_EN
    localparam logic [CW-1:0] REP_LAST = CW'(REPEAT_CYCLES - 1);
    logic [CW-1:0] rcnt;
    logic          rep_hold;

    // cap is zero after a chord entry, so sync_q == cap with a button down means a single accepted button is held
    assign rep_hold = (state == HELD) && any && (sync_q == cap);
    assign rep_fire = rep_hold && (rcnt == REP_LAST);

    // repeat timer runs only while the accepted button is held alone
    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i)
            rcnt <= '0;
        else
            rcnt <= (rep_hold && !rep_fire) ? rcnt + 1'b1 : '0;
    end
`else
    assign rep_fire = 1'b0;
`endif

    // press/release debounce FSM with registered valid and direction
    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            state       <= IDLE;
            cap         <= 4'b0000;
            cnt         <= '0;
            valid_o     <= 1'b0;
            direction_o <= 2'b00;
        end else begin
            valid_o <= 1'b0;
            case (state)
                IDLE: begin
                    if (one_hot) begin
                        cap   <= sync_q;
                        cnt   <= CW'(1);
                        state <= PRESS;
                    end else if (any) begin
                        cap   <= 4'b0000;
                        cnt   <= '0;
                        state <= HELD;
                    end
                end
                PRESS: begin
                    if (sync_q != cap) begin
                        cnt   <= '0;
                        state <= IDLE;
                    end else if (cnt == DEB_LAST) begin
                        valid_o     <= 1'b1;
                        direction_o <= enc;
                        cnt         <= '0;
                        state       <= HELD;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                HELD: begin
                    if (rep_fire) begin
                        valid_o     <= 1'b1;
                        direction_o <= enc;
                    end
                    if (any) begin
                        cnt <= '0;
                    end else if (cnt == DEB_LAST) begin
                        cnt   <= '0;
                        state <= IDLE;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                default: begin
                    cnt   <= '0;
                    state <= IDLE;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_dir_button_encoder.sv
// tb_dir_button_encoder: directed button scenarios, a sample-history model compared every cycle, and literal pins.
module tb_dir_button_encoder;
    localparam int D = 4;
    localparam int R = 8;

    logic       clk_i = 1'b0;
    logic       reset_i = 1'b1;
    logic [3:0] buttons_i = 4'b0000;
    logic [1:0] direction_o;
    logic       valid_o;

    int checks = 0;
    int errors = 0;
    int pulses = 0;

    logic       exp_valid = 1'b0;
    logic [1:0] exp_dir = 2'b00;
    logic [3:0] h1, h2, m_btn;
    bit         m_armed;
    int         m_run, m_zrun, m_rrun;

    dir_button_encoder #(.DEBOUNCE_CYCLES(D), .REPEAT_CYCLES(R)) dut (
        .clk_i      (clk_i),
        .reset_i    (reset_i),
        .buttons_i  (buttons_i),
        .direction_o(direction_o),
        .valid_o    (valid_o)
    );

    always #5 clk_i = ~clk_i;

    function automatic logic [1:0] dir_of(input logic [3:0] b);
        dir_of = 2'b00;
        for (int i = 0; i < 4; i++)
            if (b[i]) dir_of = 2'(i);
    endfunction

    task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_clear();
        h1 = 4'b0000;
        h2 = 4'b0000;
        m_btn = 4'b0000;
        m_armed = 1'b1;
        m_run = 0;
        m_zrun = 0;
        m_rrun = 0;
        exp_valid = 1'b0;
        exp_dir = 2'b00;
    endtask

    // s is what the button looked like two edges ago; a run of D equal single-button samples
    // starting from an armed, all-released state is one press; D zero samples re-arm.
    task automatic model_step();
        logic [3:0] s;
        s = h2;
        exp_valid = 1'b0;
        if (m_armed) begin
            if (m_run > 0) begin
                if (s == m_btn) begin
                    m_run++;
                    if (m_run == D) begin
                        exp_valid = 1'b1;
                        exp_dir = dir_of(m_btn);
                        m_armed = 1'b0;
                        m_zrun = 0;
                        m_rrun = 0;
                    end
                end else begin
                    m_run = 0;
                end
            end else if ($countones(s) == 1) begin
                m_btn = s;
                m_run = 1;
            end else if (s != 4'b0000) begin
                m_armed = 1'b0;
                m_zrun = 0;
                m_rrun = 0;
                m_btn = 4'b0000;
            end
        end else if (s == 4'b0000) begin
            m_rrun = 0;
            m_zrun++;
            if (m_zrun == D) begin
                m_armed = 1'b1;
                m_run = 0;
            end
        end else begin
            m_zrun = 0;
`ifdef DIR_AUTOREPEAT_EN
            if (s == m_btn) begin
                m_rrun++;
                if (m_rrun == R) begin
                    exp_valid = 1'b1;
                    exp_dir = dir_of(m_btn);
                    m_rrun = 0;
                end
            end else begin
                m_rrun = 0;
            end
`endif
        end
        h2 = h1;
        h1 = buttons_i;
    endtask

    initial begin
        model_clear();
        forever begin
            @(posedge clk_i or posedge reset_i);
            if (reset_i) model_clear();
            else model_step();
        end
    end

    initial begin
        forever begin
            @(negedge clk_i);
            check("cyc_valid", 8'(valid_o), 8'(exp_valid));
            check("cyc_dir", 8'(direction_o), 8'(exp_dir));
            if (valid_o === 1'b1) pulses++;
        end
    end

    task automatic cyc(input int n);
        repeat (n) begin
            @(posedge clk_i);
            #2;
        end
    endtask

    task automatic press(input logic [3:0] b, input int n);
        buttons_i = b;
        cyc(n);
    endtask

    initial begin
        int p0;
        cyc(3);
        check("reset_valid", 8'(valid_o), 8'd0);
        check("reset_dir", 8'(direction_o), 8'd0);
        reset_i = 1'b0;
        press(4'b0000, 4);

        p0 = pulses;
        press(4'b0100, 5);
        check("s_early", 8'(valid_o), 8'd0);
        cyc(1);
        check("s_rise", 8'(valid_o), 8'd1);
        check("s_dir", 8'(direction_o), 8'd2);
        cyc(1);
        check("s_fall", 8'(valid_o), 8'd0);
        check("s_dir_hold", 8'(direction_o), 8'd2);
        cyc(3);
        press(4'b0000, 10);
        check("s_count", 8'(pulses - p0), 8'd1);
        p0 = pulses;
        press(4'b1000, 10);
        press(4'b0000, 10);
        check("w_count", 8'(pulses - p0), 8'd1);
        check("w_dir", 8'(direction_o), 8'd3);

        p0 = pulses;
        repeat (5) begin
            press(4'b0001, 2);
            press(4'b0000, 1);
        end
        press(4'b0000, 10);
        check("bounce_count", 8'(pulses - p0), 8'd0);
        press(4'b0001, 10);
        press(4'b0000, 10);
        check("n_count", 8'(pulses - p0), 8'd1);
        check("n_dir", 8'(direction_o), 8'd0);

        p0 = pulses;
        press(4'b0011, 20);
        press(4'b0000, 10);
        check("chord_count", 8'(pulses - p0), 8'd0);
        press(4'b0010, 10);
        press(4'b0000, 10);
        check("e_count", 8'(pulses - p0), 8'd1);
        check("e_dir", 8'(direction_o), 8'd1);

        p0 = pulses;
        press(4'b0001, 10);
        repeat (4) begin
            press(4'b0000, 2);
            press(4'b0001, 1);
        end
        press(4'b0001, 5);
        check("glitch_count", 8'(pulses - p0), 8'd1);
        press(4'b0000, 3);
        press(4'b0001, 7);
        check("short_release", 8'(pulses - p0), 8'd1);
        press(4'b0000, 4);
        press(4'b0001, 7);
        check("exact_release", 8'(pulses - p0), 8'd2);
        press(4'b0000, 10);

        p0 = pulses;
        press(4'b0100, 3);
        press(4'b0000, 10);
        check("short_press", 8'(pulses - p0), 8'd0);
        press(4'b0100, 4);
        press(4'b0000, 10);
        check("exact_press", 8'(pulses - p0), 8'd1);
        check("exact_dir", 8'(direction_o), 8'd2);

        p0 = pulses;
        press(4'b1000, 4);
        reset_i = 1'b1;
        #1;
        check("rst_async_valid", 8'(valid_o), 8'd0);
        check("rst_async_dir", 8'(direction_o), 8'd0);
        cyc(2);
        reset_i = 1'b0;
        cyc(5);
        check("rst_early", 8'(valid_o), 8'd0);
        cyc(1);
        check("rst_rise", 8'(valid_o), 8'd1);
        check("rst_dir", 8'(direction_o), 8'd3);
        cyc(3);
        press(4'b0000, 10);
        check("rst_count", 8'(pulses - p0), 8'd1);

        p0 = pulses;
        press(4'b0010, 40);
        press(4'b0000, 10);
`ifdef DIR_AUTOREPEAT_EN
        check("hold_count", 8'(pulses - p0), 8'd5);
`else
        check("hold_count", 8'(pulses - p0), 8'd1);
`endif
        check("hold_dir", 8'(direction_o), 8'd1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
